if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter NOOP_WORD, default 32'h0000_0013 (addi x0,x0,0), bubble instruction word.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  system reset; one clock; reset is synchronous and active-high.
REQ-005 stall  input  1  ID-stage load-use stall; hold the IF/ID register.
REQ-006 take_branch  input  1  EX-stage redirect, taken branch or jump.
REQ-007 branch_target  input  32  redirect PC; bits [1:0] ignored, treated as 0.
REQ-008 Imem2proc_data  input  32  instruction word for the address presented this cycle.
REQ-009 Imem2proc_valid  input  1  Imem2proc_data valid this cycle; meaningful only while proc2Imem_req=1.
REQ-010 proc2Imem_req  output  1  fetch request; combinational from state.
REQ-011 proc2Imem_addr  output  32  fetch address = PC register; bits [1:0] always 0.
REQ-012 if_id_IR  output  32  registered instruction to ID.
REQ-013 if_id_PC  output  32  registered PC of if_id_IR.
REQ-014 if_id_NPC  output  32  registered if_id_PC+4.
REQ-015 if_id_valid_inst  output  1  registered; if_id_IR is a real fetched instruction.

Function
REQ-016 Memory protocol: request-hold; data valid only in a cycle with req=1, for that cycle's address; changing addr or dropping req abandons the request, no late responses.
REQ-017 State machine, two states: RUN (skid empty), FULL (skid holds {instr, pc}).
REQ-018 proc2Imem_req = 1 in RUN, 0 in FULL, 0 while rst=1.
REQ-019 RUN, stall=0, valid=1: IF/ID <= {data, PC, PC+4, valid 1}; PC <= PC+4.
REQ-020 RUN, stall=0, valid=0: IF/ID <= {NOOP_WORD, PC, PC+4, valid 0} (bubble); PC holds.
REQ-021 RUN, stall=1, valid=1: skid <= {data, PC}; PC <= PC+4; IF/ID holds; next state FULL.
REQ-022 RUN, stall=1, valid=0: PC, IF/ID hold; stay RUN.
REQ-023 FULL, stall=1: PC, skid, IF/ID hold; stay FULL.
REQ-024 FULL, stall=0: IF/ID <= {skid instr, skid pc, skid pc+4, valid 1}; next state RUN; no fetch this cycle.
REQ-025 take_branch=1 overrides stall in any state: PC <= {branch_target[31:2],2'b00}; IF/ID <= {NOOP_WORD, 0, 0, valid 0}; skid cleared; next state RUN; Imem2proc_data this cycle discarded.
REQ-026 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
REQ-027 Each fetched word delivered to ID exactly once and in program order; no word dropped across stall except by take_branch.
REQ-028 Max throughput one instruction per cycle with zero-wait memory and no stall/branch.

Reset
REQ-029 rst=1 at edge: PC <= RESET_PC; if_id_IR <= NOOP_WORD; if_id_PC, if_id_NPC <= 0; if_id_valid_inst <= 0; skid cleared; state RUN.
REQ-030 rst has priority over take_branch and stall; reset mid-FULL discards the skid word.
REQ-031 First fetch request issued in cycle after rst deasserts, address RESET_PC.

Verification
REQ-032 Zero-wait memory, 4 cycles after reset, no stall -> if_id_PC 0,4,8,C on consecutive cycles, valid 1 each.
REQ-033 Memory valid every 3rd cycle -> two bubbles (NOOP_WORD, valid 0) between each real instruction; PC advances only on valid.
REQ-034 stall=1 for 3 cycles while valid=1 at PC 8 -> req drops after 1 cycle, IF/ID holds PC 4; on stall release IF/ID PC 8 then PC C next cycle.
REQ-035 take_branch=1, target 32'h0000_0103, during FULL with stall=1 -> next cycle addr 32'h100, IF/ID valid 0, skid word never delivered.
REQ-036 RESET_PC=32'hFFFF_FFF8, zero-wait -> if_id_PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 rst asserted for one cycle while FULL -> next cycle state RUN, addr RESET_PC, if_id_valid_inst 0.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with request-hold imem port and one-entry skid buffer
// Feeds the IF/ID register; a fetch that returns under stall is parked in the skid entry.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] Imem2proc_data,
  input  logic        Imem2proc_valid,
  output logic        proc2Imem_req,
  output logic [31:0] proc2Imem_addr,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic [31:0] if_id_NPC,
  output logic        if_id_valid_inst
);

  typedef enum logic {RUN, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] npc_q, npc_d;
  logic        vld_q, vld_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    skid_ir_d = skid_ir_q;
    skid_pc_d = skid_pc_q;
    ir_d      = ir_q;
    id_pc_d   = id_pc_q;
    npc_d     = npc_q;
    vld_d     = vld_q;
    if (take_branch) begin
      // Redirect wins over stall: flush IF/ID and the skid, drop this cycle's data.
      state_d   = RUN;
      pc_d      = branch_target & 32'hFFFF_FFFC;
      skid_ir_d = 32'd0;
      skid_pc_d = 32'd0;
      ir_d      = NOOP_WORD;
      id_pc_d   = 32'd0;
      npc_d     = 32'd0;
      vld_d     = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (Imem2proc_valid) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_ir_d = Imem2proc_data;
              skid_pc_d = pc_q;
              state_d   = FULL;
            end else begin
              ir_d    = Imem2proc_data;
              id_pc_d = pc_q;
              npc_d   = pc_plus4;
              vld_d   = 1'b1;
            end
          end else if (!stall) begin
            ir_d    = NOOP_WORD;
            id_pc_d = pc_q;
            npc_d   = pc_plus4;
            vld_d   = 1'b0;
          end
        end
        FULL: begin
          if (!stall) begin
            ir_d      = skid_ir_q;
            id_pc_d   = skid_pc_q;
            npc_d     = skid_pc_q + 32'd4;
            vld_d     = 1'b1;
            skid_ir_d = 32'd0;
            skid_pc_d = 32'd0;
            state_d   = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC & 32'hFFFF_FFFC;
      skid_ir_q <= 32'd0;
      skid_pc_q <= 32'd0;
      ir_q      <= NOOP_WORD;
      id_pc_q   <= 32'd0;
      npc_q     <= 32'd0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      skid_ir_q <= skid_ir_d;
      skid_pc_q <= skid_pc_d;
      ir_q      <= ir_d;
      id_pc_q   <= id_pc_d;
      npc_q     <= npc_d;
      vld_q     <= vld_d;
    end
  end

  assign proc2Imem_req    = (state_q == RUN) && !rst;
  assign proc2Imem_addr   = pc_q;
  assign if_id_IR         = ir_q;
  assign if_id_PC         = id_pc_q;
  assign if_id_NPC        = npc_q;
  assign if_id_valid_inst = vld_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage
// Two instances: default RESET_PC, and RESET_PC near the top of memory for wraparound.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, take_branch, mem_valid;
  logic [31:0] branch_target;
  logic        req_a, vld_a, req_b, vld_b;
  logic [31:0] data_a, addr_a, ir_a, pc_a, npc_a;
  logic [31:0] data_b, addr_b, ir_b, pc_b, npc_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA500_0000;
  endfunction

  assign data_a = memf(addr_a);
  assign data_b = memf(addr_b);

  if_stage dut_a (
    .clk(clk), .rst(rst), .stall(stall), .take_branch(take_branch),
    .branch_target(branch_target), .Imem2proc_data(data_a), .Imem2proc_valid(mem_valid),
    .proc2Imem_req(req_a), .proc2Imem_addr(addr_a), .if_id_IR(ir_a),
    .if_id_PC(pc_a), .if_id_NPC(npc_a), .if_id_valid_inst(vld_a)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .stall(1'b0), .take_branch(1'b0),
    .branch_target(32'd0), .Imem2proc_data(data_b), .Imem2proc_valid(1'b1),
    .proc2Imem_req(req_b), .proc2Imem_addr(addr_b), .if_id_IR(ir_b),
    .if_id_PC(pc_b), .if_id_NPC(npc_b), .if_id_valid_inst(vld_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                            input logic [31:0] npc, input logic v);
    check({tag, "_ir"}, ir_a, ir);
    check({tag, "_pc"}, pc_a, pc);
    check({tag, "_npc"}, npc_a, npc);
    check({tag, "_valid"}, {31'd0, vld_a}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; take_branch = 1'b0; mem_valid = 1'b0; branch_target = 32'd0;
    step();
    check_ifid("reset", 32'h13, 32'h0, 32'h0, 1'b0);
    check("reset_req", {31'd0, req_a}, 32'd0);
    check("reset_addr", addr_a, 32'h0);
    check("reset_b_addr", addr_b, 32'hFFFF_FFF8);
    rst = 1'b0;
    #1;
    check("first_req", {31'd0, req_a}, 32'd1);

    // zero-wait streaming, plus wraparound on instance B
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_ifid("stream", memf(32'(i * 4)), 32'(i * 4), 32'(i * 4 + 4), 1'b1);
      if (i < 3) begin
        check("wrap_pc", pc_b, 32'hFFFF_FFF8 + 32'(i * 4));
        check("wrap_ir", ir_b, memf(32'hFFFF_FFF8 + 32'(i * 4)));
        check("wrap_valid", {31'd0, vld_b}, 32'd1);
      end
      if (i == 1) check("wrap_npc", npc_b, 32'h0);
    end
    check("stream_addr", addr_a, 32'h10);

    // memory valid every third cycle -> two bubbles between real instructions
    for (int r = 0; r < 2; r++) begin
      mem_valid = 1'b0;
      step(); check_ifid("bubble1", 32'h13, 32'h10 + 32'(r * 4), 32'h14 + 32'(r * 4), 1'b0);
      step(); check_ifid("bubble2", 32'h13, 32'h10 + 32'(r * 4), 32'h14 + 32'(r * 4), 1'b0);
      mem_valid = 1'b1;
      step(); check_ifid("slowvalid", memf(32'h10 + 32'(r * 4)), 32'h10 + 32'(r * 4),
                         32'h14 + 32'(r * 4), 1'b1);
    end

    // stall with valid data at PC 8
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    check("pre_stall_addr", addr_a, 32'h8);
    stall = 1'b1;
    step();
    check("stall_req_drop", {31'd0, req_a}, 32'd0);
    check_ifid("stall_hold1", memf(32'h4), 32'h4, 32'h8, 1'b1);
    step(); step();
    check_ifid("stall_hold3", memf(32'h4), 32'h4, 32'h8, 1'b1);
    check("stall_addr", addr_a, 32'hC);
    stall = 1'b0;
    step();
    check_ifid("skid_out", memf(32'h8), 32'h8, 32'hC, 1'b1);
    check("skid_out_req", {31'd0, req_a}, 32'd1);
    step();
    check_ifid("after_skid", memf(32'hC), 32'hC, 32'h10, 1'b1);

    // branch during FULL with stall held
    stall = 1'b1;
    step();
    check("full_req", {31'd0, req_a}, 32'd0);
    take_branch = 1'b1; branch_target = 32'h0000_0103;
    step();
    take_branch = 1'b0;
    check("br_addr", addr_a, 32'h100);
    check_ifid("br_flush", 32'h13, 32'h0, 32'h0, 1'b0);
    check("br_req", {31'd0, req_a}, 32'd1);
    stall = 1'b0;
    step();
    check_ifid("br_first", memf(32'h100), 32'h100, 32'h104, 1'b1);

    // RUN, stall, no data: everything holds
    stall = 1'b1; mem_valid = 1'b0;
    step();
    check_ifid("run_stall_idle", memf(32'h100), 32'h100, 32'h104, 1'b1);
    check("run_stall_idle_addr", addr_a, 32'h104);

    // reset while FULL beats a simultaneous branch and drops the skid word
    mem_valid = 1'b1;
    step();
    check("full2_req", {31'd0, req_a}, 32'd0);
    rst = 1'b1; take_branch = 1'b1; branch_target = 32'h0000_0200;
    step();
    rst = 1'b0; take_branch = 1'b0;
    #1;
    check("rst_full_addr", addr_a, 32'h0);
    check("rst_full_req", {31'd0, req_a}, 32'd1);
    check_ifid("rst_full", 32'h13, 32'h0, 32'h0, 1'b0);
    stall = 1'b0;
    step();
    check_ifid("rst_full_next", memf(32'h0), 32'h0, 32'h4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
